// File: rtl/lift_floor_ctrl.sv
// Lift floor-sequencing controller: latches calls, serves floors in SCAN order,
// and drives the status-LED blinker enables (blink while moving, steady while door open).
//
// state   | meaning
// --------+----------------------------------------------------------
// ST_IDLE | car parked, door closed; picks the next floor to serve
// ST_MOVE | travelling one floor per TRAVEL_CYCLES in dir_up direction
// ST_DOOR | door open at current floor for DOOR_CYCLES (restartable)
module lift_floor_ctrl #(
    parameter int unsigned N_FLOORS      = 4,
    parameter int unsigned FW            = $clog2(N_FLOORS),
    parameter int unsigned TRAVEL_CYCLES = 100_000_000,
    parameter int unsigned DOOR_CYCLES   = 150_000_000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [N_FLOORS-1:0] req,
    output logic [FW-1:0]       floor,
    output logic                dir_up,
    output logic [N_FLOORS-1:0] pending,
    output logic                enable_inter,
    output logic                enable_fijo
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MOVE = 2'd1,
        ST_DOOR = 2'd2
    } state_t;

    localparam logic [31:0] TRAVEL_LAST = 32'(TRAVEL_CYCLES - 1);
    localparam logic [31:0] DOOR_LAST   = 32'(DOOR_CYCLES - 1);

    state_t              state_q, state_d;
    logic [FW-1:0]       floor_q, floor_d;
    logic                dir_up_q, dir_up_d;
    logic [N_FLOORS-1:0] pending_q, pending_d;
    logic [31:0]         cnt_q, cnt_d;

    logic                call_above, call_below;
    logic [FW-1:0]       step_floor;
    logic                beyond_up, beyond_dn;

    // Call summary relative to the current floor and to the floor being arrived at.
    always_comb begin
        call_above = 1'b0;
        call_below = 1'b0;
        beyond_up  = 1'b0;
        beyond_dn  = 1'b0;
        step_floor = dir_up_q ? floor_q + FW'(1) : floor_q - FW'(1);
        for (int i = 0; i < int'(N_FLOORS); i++) begin
            if (pending_q[i]) begin
                if (i > int'(floor_q))    call_above = 1'b1;
                if (i < int'(floor_q))    call_below = 1'b1;
                if (i > int'(step_floor)) beyond_up  = 1'b1;
                if (i < int'(step_floor)) beyond_dn  = 1'b1;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        floor_d   = floor_q;
        dir_up_d  = dir_up_q;
        cnt_d     = cnt_q;
        pending_d = pending_q | req;

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (pending_q[floor_q]) begin
                    state_d            = ST_DOOR;
                    pending_d[floor_q] = 1'b0;
                end else if (call_above && call_below) begin
                    state_d = ST_MOVE;
                end else if (call_above) begin
                    dir_up_d = 1'b1;
                    state_d  = ST_MOVE;
                end else if (call_below) begin
                    dir_up_d = 1'b0;
                    state_d  = ST_MOVE;
                end
            end

            ST_MOVE: begin
                cnt_d = cnt_q + 32'd1;
                if (cnt_q == TRAVEL_LAST) begin
                    cnt_d   = '0;
                    floor_d = step_floor;
                    if (pending_q[step_floor]) begin
                        state_d               = ST_DOOR;
                        pending_d[step_floor] = 1'b0;
                    end else if (dir_up_q ? beyond_up : beyond_dn) begin
                        state_d = ST_MOVE;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end

            ST_DOOR: begin
                // A press at the open floor keeps the door open instead of queueing a call.
                if (req[floor_q]) begin
                    pending_d[floor_q] = pending_q[floor_q];
                    cnt_d              = '0;
                end else if (cnt_q == DOOR_LAST) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end

            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            floor_q   <= '0;
            dir_up_q  <= 1'b1;
            pending_q <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            floor_q   <= floor_d;
            dir_up_q  <= dir_up_d;
            pending_q <= pending_d;
            cnt_q     <= cnt_d;
        end
    end

    assign floor        = floor_q;
    assign dir_up       = dir_up_q;
    assign pending      = pending_q;
    assign enable_inter = (state_q == ST_MOVE);
    assign enable_fijo  = (state_q == ST_DOOR);

endmodule

// File: tb/tb_lift_floor_ctrl.sv
// Directed bench for lift_floor_ctrl with TRAVEL_CYCLES=4, DOOR_CYCLES=6, four floors.
// Expected values are hand-derived edge by edge from the call-to-door timing.
module tb_lift_floor_ctrl;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic [1:0] floor;
    logic       dir_up;
    logic [3:0] pending;
    logic       enable_inter;
    logic       enable_fijo;

    int total;
    int bad;

    lift_floor_ctrl #(
        .N_FLOORS      (4),
        .TRAVEL_CYCLES (4),
        .DOOR_CYCLES   (6)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req          (req),
        .floor        (floor),
        .dir_up       (dir_up),
        .pending      (pending),
        .enable_inter (enable_inter),
        .enable_fijo  (enable_fijo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic tickn(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_floor"},   32'(floor),        32'd0);
        chk({tag, "_pending"}, 32'(pending),      32'd0);
        chk({tag, "_dir_up"},  32'(dir_up),       32'd1);
        chk({tag, "_inter"},   32'(enable_inter), 32'd0);
        chk({tag, "_fijo"},    32'(enable_fijo),  32'd0);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        req   = 4'b0000;

        repeat (2) @(posedge clk);
        #1;
        chk_reset_vals("reset");
        rst_n = 1'b1;
        tick();
        chk("idle_inter", 32'(enable_inter), 32'd0);
        chk("idle_fijo",  32'(enable_fijo),  32'd0);

        // Same-floor call at floor 0
        req = 4'b0001;
        tick();
        req = 4'b0000;
        chk("same_pend_t1",  32'(pending),     32'h1);
        chk("same_fijo_t1",  32'(enable_fijo), 32'd0);
        tick();
        chk("same_fijo_t2",  32'(enable_fijo), 32'd1);
        chk("same_pend_t2",  32'(pending),     32'h0);
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("same_fijo_hold",  32'(enable_fijo),  32'd1);
            chk("same_inter_hold", 32'(enable_inter), 32'd0);
        end
        tick();
        chk("same_fijo_end",  32'(enable_fijo),  32'd0);
        chk("same_inter_end", 32'(enable_inter), 32'd0);

        // Travel 0 -> 2, then door restart at floor 2
        req = 4'b0100;
        tick();
        req = 4'b0000;
        chk("trav_pend_t1",  32'(pending),      32'h4);
        chk("trav_inter_t1", 32'(enable_inter), 32'd0);
        tick();
        chk("trav_inter_t2", 32'(enable_inter), 32'd1);
        chk("trav_floor_t2", 32'(floor),        32'd0);
        tickn(3);
        chk("trav_floor_t5", 32'(floor),        32'd0);
        chk("trav_inter_t5", 32'(enable_inter), 32'd1);
        tick();
        chk("trav_floor_t6", 32'(floor),        32'd1);
        chk("trav_inter_t6", 32'(enable_inter), 32'd1);
        tickn(3);
        chk("trav_floor_t9", 32'(floor),        32'd1);
        chk("trav_inter_t9", 32'(enable_inter), 32'd1);
        tick();
        chk("trav_floor_t10", 32'(floor),        32'd2);
        chk("trav_inter_t10", 32'(enable_inter), 32'd0);
        chk("trav_fijo_t10",  32'(enable_fijo),  32'd1);
        chk("trav_pend_t10",  32'(pending),      32'h0);
        tickn(4);
        chk("door_fijo_c4", 32'(enable_fijo), 32'd1);
        req = 4'b0100;
        tick();
        req = 4'b0000;
        chk("restart_fijo", 32'(enable_fijo), 32'd1);
        chk("restart_pend", 32'(pending),     32'h0);
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("restart_fijo_hold", 32'(enable_fijo), 32'd1);
            chk("restart_pend_hold", 32'(pending),     32'h0);
        end
        tick();
        chk("restart_fijo_end",  32'(enable_fijo),  32'd0);
        chk("restart_inter_end", 32'(enable_inter), 32'd0);
        chk("restart_floor_end", 32'(floor),        32'd2);

        // Move down to floor 1 to set up the SCAN scenario
        req = 4'b0010;
        tick();
        req = 4'b0000;
        tick();
        chk("down_inter", 32'(enable_inter), 32'd1);
        chk("down_dir",   32'(dir_up),       32'd0);
        tickn(4);
        chk("down_floor", 32'(floor),        32'd1);
        chk("down_fijo",  32'(enable_fijo),  32'd1);
        tickn(6);
        chk("down_done_fijo", 32'(enable_fijo), 32'd0);

        // SCAN: heading up to 3, new calls at 0 and 2
        req = 4'b1000;
        tick();
        req = 4'b0000;
        tick();
        chk("scan_inter_up", 32'(enable_inter), 32'd1);
        chk("scan_dir_up",   32'(dir_up),       32'd1);
        chk("scan_floor1",   32'(floor),        32'd1);
        tick();
        req = 4'b0101;
        tick();
        req = 4'b0000;
        chk("scan_pend_all", 32'(pending), 32'hD);
        tickn(2);
        chk("scan_stop2_floor", 32'(floor),        32'd2);
        chk("scan_stop2_fijo",  32'(enable_fijo),  32'd1);
        chk("scan_stop2_inter", 32'(enable_inter), 32'd0);
        chk("scan_stop2_pend",  32'(pending),      32'h9);
        tickn(6);
        chk("scan_idle2_fijo",  32'(enable_fijo),  32'd0);
        chk("scan_idle2_inter", 32'(enable_inter), 32'd0);
        chk("scan_idle2_dir",   32'(dir_up),       32'd1);
        tick();
        chk("scan_up3_inter", 32'(enable_inter), 32'd1);
        chk("scan_up3_dir",   32'(dir_up),       32'd1);
        tickn(4);
        chk("scan_stop3_floor", 32'(floor),       32'd3);
        chk("scan_stop3_fijo",  32'(enable_fijo), 32'd1);
        chk("scan_stop3_pend",  32'(pending),     32'h1);
        tickn(6);
        chk("scan_idle3_fijo", 32'(enable_fijo), 32'd0);
        tick();
        chk("scan_rev_inter", 32'(enable_inter), 32'd1);
        chk("scan_rev_dir",   32'(dir_up),       32'd0);
        chk("scan_rev_floor", 32'(floor),        32'd3);
        tickn(4);
        chk("scan_pass2_floor", 32'(floor),        32'd2);
        chk("scan_pass2_inter", 32'(enable_inter), 32'd1);
        tickn(4);
        chk("scan_pass1_floor", 32'(floor),        32'd1);
        chk("scan_pass1_inter", 32'(enable_inter), 32'd1);
        tickn(4);
        chk("scan_stop0_floor", 32'(floor),       32'd0);
        chk("scan_stop0_fijo",  32'(enable_fijo), 32'd1);
        chk("scan_stop0_pend",  32'(pending),     32'h0);
        tickn(6);
        chk("scan_end_fijo",  32'(enable_fijo),  32'd0);
        chk("scan_end_inter", 32'(enable_inter), 32'd0);

        // Asynchronous reset mid-travel at floor 2 with a call to 3 outstanding
        req = 4'b1000;
        tick();
        req = 4'b0000;
        tickn(9);
        chk("mid_floor", 32'(floor),        32'd2);
        chk("mid_inter", 32'(enable_inter), 32'd1);
        chk("mid_pend",  32'(pending),      32'h8);
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_vals("async_rst");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("post_rst_inter", 32'(enable_inter), 32'd0);
            chk("post_rst_fijo",  32'(enable_fijo),  32'd0);
            chk("post_rst_floor", 32'(floor),        32'd0);
            chk("post_rst_pend",  32'(pending),      32'h0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
